// File: rtl/microwave_pkg.sv
// Shared definitions for the microwave timer datapath.
//   state_e              : control FSM state encoding (ST_IDLE, ST_RUN, ST_PAUSE)
//   BCD_MAX              : largest legal BCD digit
//   SEC_TENS_MAX_DEFAULT : seconds-tens value restored on a borrow from minutes
//   is_bcd()             : true when a keyed digit is a legal BCD value
package microwave_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam int unsigned SEC_TENS_MAX_DEFAULT = 5;

  function automatic logic is_bcd(logic [3:0] v);
    return v <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD digit of a down-counter chain.
//   clock, reset   : rising-edge clock, synchronous active-high reset
//   clear          : synchronous clear to 0 (overrides load/decrement)
//   load           : capture load_value
//   load_value     : value to capture
//   dec            : decrement enable for the whole chain
//   borrow_in      : this digit steps only when all lower digits are 0
//   value          : registered digit value
//   borrow_out     : borrow_in and this digit is 0 (next digit must step)
module bcd_digit_down #(
  parameter logic [3:0] WRAP_VALUE = 4'd9
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       load,
  input  logic [3:0] load_value,
  input  logic       dec,
  input  logic       borrow_in,
  output logic [3:0] value,
  output logic       borrow_out
);

  logic [3:0] value_q;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      value_q <= 4'd0;
    end else if (load) begin
      value_q <= load_value;
    end else if (dec && borrow_in) begin
      value_q <= (value_q == 4'd0) ? WRAP_VALUE : value_q - 4'd1;
    end
  end

  assign value      = value_q;
  assign borrow_out = borrow_in && (value_q == 4'd0);

endmodule

// File: rtl/timer_mmss_receiver.sv
// MM:SS countdown register fed by the keypad encoder link.
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   d, loadn            : BCD digit and active-low load strobe (shift-in on falling edge)
//   pgt_1hz             : 1 Hz square wave, one countdown tick per rising edge
//   startn/stopn/clearn : active-low level requests
//   door_closed         : counting allowed only while 1
//   sec_ones..min_tens  : BCD digit outputs
//   running             : 1 while in ST_RUN
//   done                : one-cycle pulse when a running countdown reaches 00:00
module timer_mmss_receiver
  import microwave_pkg::*;
#(
  parameter int unsigned SEC_TENS_MAX = SEC_TENS_MAX_DEFAULT,
  // Fixed MM:SS layout; only 4 is supported.
  parameter int unsigned DIGITS = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] d,
  input  logic       loadn,
  input  logic       pgt_1hz,
  input  logic       startn,
  input  logic       stopn,
  input  logic       clearn,
  input  logic       door_closed,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       running,
  output logic       done
);

  // Input capture and edge detection. The second stage of each pair is the
  // previous sample, so an event lands one clock after the input moves and
  // acts on the digits one clock later.
  logic loadn_q, loadn_prev_q;
  logic pgt_q, pgt_prev_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      loadn_q      <= 1'b1;
      loadn_prev_q <= 1'b1;
      pgt_q        <= 1'b0;
      pgt_prev_q   <= 1'b0;
    end else begin
      loadn_q      <= loadn;
      loadn_prev_q <= loadn_q;
      pgt_q        <= pgt_1hz;
      pgt_prev_q   <= pgt_q;
    end
  end

  logic load_ev, tick;
  assign load_ev = loadn_prev_q && !loadn_q;
  assign tick    = pgt_q && !pgt_prev_q;

  state_e state_q;
  logic   done_q;

  logic so_borrow, st_borrow, mo_borrow, mt_borrow;
  logic [4*DIGITS-1:0] digits_all;
  logic count_zero, count_one;
  logic stop_req, start_ok, key_ok;
  logic clear_digits, shift_en, dec_en;

  assign digits_all = {min_tens, min_ones, sec_tens, sec_ones};
  // With the chain's borrow fed by a constant 1, the top borrow-out is high
  // exactly when every digit is 0.
  assign count_zero = mt_borrow;
  // A decrement from 00:01 is the only one that lands on 00:00.
  assign count_one  = (digits_all == {{(4*DIGITS-4){1'b0}}, 4'd1});
  assign stop_req   = !stopn || !door_closed;
  assign start_ok   = !startn && door_closed;
  assign key_ok     = load_ev && is_bcd(d);

  // Datapath controls; priority clear > stop > tick > start > load.
  always_comb begin
    clear_digits = !clearn;
    shift_en     = 1'b0;
    dec_en       = 1'b0;
    unique case (state_q)
      ST_IDLE:  shift_en = clearn && !(start_ok && !count_zero) && key_ok;
      ST_RUN:   dec_en   = clearn && !stop_req && tick;
      ST_PAUSE: shift_en = clearn && !start_ok && key_ok;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (!clearn) begin
        state_q <= ST_IDLE;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (start_ok && !count_zero) state_q <= ST_RUN;
          end
          ST_RUN: begin
            if (stop_req) begin
              state_q <= ST_PAUSE;
            end else if (tick && count_one) begin
              state_q <= ST_IDLE;
              done_q  <= 1'b1;
            end
          end
          ST_PAUSE: begin
            if (start_ok) begin
              state_q <= ST_RUN;
            end else if (shift_en) begin
              // Editing a paused time abandons the paused run.
              state_q <= ST_IDLE;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign running = (state_q == ST_RUN);
  assign done    = done_q;

  bcd_digit_down #(.WRAP_VALUE(BCD_MAX)) u_sec_ones (
    .clock      (clock),
    .reset      (reset),
    .clear      (clear_digits),
    .load       (shift_en),
    .load_value (d),
    .dec        (dec_en),
    .borrow_in  (1'b1),
    .value      (sec_ones),
    .borrow_out (so_borrow)
  );

  bcd_digit_down #(.WRAP_VALUE(4'(SEC_TENS_MAX))) u_sec_tens (
    .clock      (clock),
    .reset      (reset),
    .clear      (clear_digits),
    .load       (shift_en),
    .load_value (sec_ones),
    .dec        (dec_en),
    .borrow_in  (so_borrow),
    .value      (sec_tens),
    .borrow_out (st_borrow)
  );

  bcd_digit_down #(.WRAP_VALUE(BCD_MAX)) u_min_ones (
    .clock      (clock),
    .reset      (reset),
    .clear      (clear_digits),
    .load       (shift_en),
    .load_value (sec_tens),
    .dec        (dec_en),
    .borrow_in  (st_borrow),
    .value      (min_ones),
    .borrow_out (mo_borrow)
  );

  // Never wraps in practice: reaching 00:00 stops the count first.
  bcd_digit_down #(.WRAP_VALUE(BCD_MAX)) u_min_tens (
    .clock      (clock),
    .reset      (reset),
    .clear      (clear_digits),
    .load       (shift_en),
    .load_value (min_ones),
    .dec        (dec_en),
    .borrow_in  (mo_borrow),
    .value      (min_tens),
    .borrow_out (mt_borrow)
  );

endmodule

// File: tb/tb_timer_mmss_receiver.sv
module tb_timer_mmss_receiver;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] d = 4'd0;
  logic       loadn = 1'b1;
  logic       pgt_1hz = 1'b0;
  logic       startn = 1'b1;
  logic       stopn = 1'b1;
  logic       clearn = 1'b1;
  logic       door_closed = 1'b1;
  logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
  logic       running, done;

  int tests_run = 0;
  int tests_failed = 0;
  int done_count = 0;

  timer_mmss_receiver dut (
    .clock       (clock),
    .reset       (reset),
    .d           (d),
    .loadn       (loadn),
    .pgt_1hz     (pgt_1hz),
    .startn      (startn),
    .stopn       (stopn),
    .clearn      (clearn),
    .door_closed (door_closed),
    .sec_ones    (sec_ones),
    .sec_tens    (sec_tens),
    .min_ones    (min_ones),
    .min_tens    (min_tens),
    .running     (running),
    .done        (done)
  );

  always #5 clock = ~clock;

  logic [15:0] digits;
  assign digits = {min_tens, min_ones, sec_tens, sec_ones};

  // done is a one-cycle pulse; the negedge sees it exactly once.
  always @(negedge clock) if (done === 1'b1) done_count++;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic key_digit(input logic [3:0] v);
    d = v;
    loadn = 1'b0;
    cyc(2);
    loadn = 1'b1;
    cyc(2);
  endtask

  task automatic tick_once();
    pgt_1hz = 1'b1;
    cyc(2);
    pgt_1hz = 1'b0;
    cyc(2);
  endtask

  task automatic pulse_start();
    startn = 1'b0;
    cyc(1);
    startn = 1'b1;
  endtask

  task automatic do_clear();
    clearn = 1'b0;
    cyc(1);
    clearn = 1'b1;
    cyc(1);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    cyc(1);
    tests_run++;
    if (digits !== 16'h0000) begin
      tests_failed++;
      $display("FAIL reset_digits: got %h expected 0000", digits);
    end
    tests_run++;
    if (running !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: running=%b done=%b expected 0 0", running, done);
    end
  endtask

  task automatic test_load_latency();
    do_clear();
    d = 4'd3;
    loadn = 1'b0;
    cyc(1);
    tests_run++;
    if (digits !== 16'h0000) begin
      tests_failed++;
      $display("FAIL load_latency_1clk: got %h expected 0000", digits);
    end
    cyc(1);
    tests_run++;
    if (digits !== 16'h0003) begin
      tests_failed++;
      $display("FAIL load_latency_2clk: got %h expected 0003", digits);
    end
    loadn = 1'b1;
    cyc(2);
  endtask

  task automatic test_countdown();
    int base;
    do_clear();
    key_digit(4'd1);
    key_digit(4'd0);
    key_digit(4'd5);
    tests_run++;
    if (digits !== 16'h0105) begin
      tests_failed++;
      $display("FAIL key_105: got %h expected 0105", digits);
    end
    base = done_count;
    pulse_start();
    tests_run++;
    if (running !== 1'b1) begin
      tests_failed++;
      $display("FAIL start_running: got %b expected 1", running);
    end
    repeat (64) tick_once();
    tests_run++;
    if (digits !== 16'h0001 || running !== 1'b1 || done_count != base) begin
      tests_failed++;
      $display("FAIL after_64_ticks: got %h run=%b dones=%0d expected 0001 1 0",
               digits, running, done_count - base);
    end
    pgt_1hz = 1'b1;
    cyc(2);
    tests_run++;
    if (done !== 1'b1 || digits !== 16'h0000 || running !== 1'b0) begin
      tests_failed++;
      $display("FAIL final_tick: done=%b digits=%h run=%b expected 1 0000 0",
               done, digits, running);
    end
    pgt_1hz = 1'b0;
    cyc(1);
    tests_run++;
    if (done !== 1'b0) begin
      tests_failed++;
      $display("FAIL done_one_cycle: got %b expected 0", done);
    end
    cyc(1);
    repeat (2) tick_once();
    tests_run++;
    if (digits !== 16'h0000 || done_count != base + 1) begin
      tests_failed++;
      $display("FAIL no_wrap: got %h dones=%0d expected 0000 1", digits, done_count - base);
    end
  endtask

  task automatic test_borrow();
    do_clear();
    key_digit(4'd1);
    key_digit(4'd0);
    key_digit(4'd0);
    pulse_start();
    tick_once();
    tests_run++;
    if (digits !== 16'h0059) begin
      tests_failed++;
      $display("FAIL borrow_100: got %h expected 0059", digits);
    end
    do_clear();
    key_digit(4'd1);
    key_digit(4'd9);
    key_digit(4'd0);
    pulse_start();
    tick_once();
    tests_run++;
    if (digits !== 16'h0189) begin
      tests_failed++;
      $display("FAIL keyed_190: got %h expected 0189", digits);
    end
    do_clear();
  endtask

  task automatic test_no_start();
    int base;
    do_clear();
    base = done_count;
    startn = 1'b0;
    cyc(3);
    startn = 1'b1;
    cyc(1);
    tests_run++;
    if (running !== 1'b0 || done_count != base) begin
      tests_failed++;
      $display("FAIL zero_start: run=%b dones=%0d expected 0 0", running, done_count - base);
    end
    key_digit(4'd5);
    door_closed = 1'b0;
    startn = 1'b0;
    cyc(3);
    startn = 1'b1;
    door_closed = 1'b1;
    cyc(1);
    tests_run++;
    if (running !== 1'b0 || digits !== 16'h0005) begin
      tests_failed++;
      $display("FAIL door_open_start: run=%b digits=%h expected 0 0005", running, digits);
    end
  endtask

  task automatic test_pause();
    do_clear();
    key_digit(4'd3);
    key_digit(4'd0);
    pulse_start();
    door_closed = 1'b0;
    cyc(1);
    tests_run++;
    if (running !== 1'b0) begin
      tests_failed++;
      $display("FAIL door_pause: run=%b expected 0", running);
    end
    repeat (2) tick_once();
    tests_run++;
    if (digits !== 16'h0030) begin
      tests_failed++;
      $display("FAIL pause_ticks: got %h expected 0030", digits);
    end
    door_closed = 1'b1;
    pulse_start();
    tests_run++;
    if (running !== 1'b1) begin
      tests_failed++;
      $display("FAIL resume: run=%b expected 1", running);
    end
    tick_once();
    tests_run++;
    if (digits !== 16'h0029) begin
      tests_failed++;
      $display("FAIL resume_tick: got %h expected 0029", digits);
    end
    // Stop coincident with a tick event: the tick is dropped.
    pgt_1hz = 1'b1;
    cyc(1);
    stopn = 1'b0;
    cyc(1);
    stopn = 1'b1;
    pgt_1hz = 1'b0;
    cyc(2);
    tests_run++;
    if (digits !== 16'h0029 || running !== 1'b0) begin
      tests_failed++;
      $display("FAIL stop_vs_tick: got %h run=%b expected 0029 0", digits, running);
    end
  endtask

  task automatic test_ignored_loads();
    pulse_start();
    key_digit(4'd7);
    tests_run++;
    if (digits !== 16'h0029 || running !== 1'b1) begin
      tests_failed++;
      $display("FAIL run_load: got %h run=%b expected 0029 1", digits, running);
    end
    do_clear();
    key_digit(4'd4);
    key_digit(4'd12);
    tests_run++;
    if (digits !== 16'h0004) begin
      tests_failed++;
      $display("FAIL bad_digit: got %h expected 0004", digits);
    end
  endtask

  task automatic test_clear_midcount();
    int base;
    do_clear();
    key_digit(4'd2);
    key_digit(4'd0);
    pulse_start();
    repeat (3) tick_once();
    tests_run++;
    if (digits !== 16'h0017) begin
      tests_failed++;
      $display("FAIL midcount: got %h expected 0017", digits);
    end
    base = done_count;
    clearn = 1'b0;
    cyc(1);
    clearn = 1'b1;
    tests_run++;
    if (digits !== 16'h0000 || running !== 1'b0) begin
      tests_failed++;
      $display("FAIL clearn_mid: got %h run=%b expected 0000 0", digits, running);
    end
    key_digit(4'd2);
    key_digit(4'd0);
    pulse_start();
    tick_once();
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    cyc(2);
    tests_run++;
    if (digits !== 16'h0000 || running !== 1'b0 || done_count != base) begin
      tests_failed++;
      $display("FAIL reset_mid: got %h run=%b dones=%0d expected 0000 0 0",
               digits, running, done_count - base);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_load_latency();
    test_countdown();
    test_borrow();
    test_no_start();
    test_pause();
    test_ignored_loads();
    test_clear_midcount();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
